// File: rtl/spgd_pkg.sv
// Shared constants and helpers for the SPGD metric path: default widths,
// ceiling log2 and a generic two's-complement sign extension.
package spgd_pkg;

  localparam int IN_WIDTH_DEF  = 12;
  localparam int OUT_WIDTH_DEF = 32;
  localparam int NUM_CH_DEF    = 4;
  localparam int AVG_LOG2_DEF  = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  localparam int CH_W = (NUM_CH_DEF > 1) ? clog2(NUM_CH_DEF) : 1;

  // Replicates bit in_w-1 of smp into every higher bit; callers keep the low bits they need.
  function automatic logic [63:0] sext(input logic [63:0] smp, input int in_w);
    logic [63:0] r;
    r = smp;
    for (int b = 0; b < 64; b++) begin
      if (b >= in_w) begin
        r[b] = smp[in_w-1];
      end else begin
        r[b] = smp[b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i,
// wrapping modulo NUM_CH. The pointer itself lives in the parent.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CW     = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [CW-1:0]     grant_idx_o,
  output logic              grant_vld_o
);

  int c;

  // Rotating priority search starting at the pointer.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    c           = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (int'(ptr_i) + i) % NUM_CH;
      if (req_i[c] && !grant_vld_o) begin
        grant_o[c]  = 1'b1;
        grant_idx_o = c[CW-1:0];
        grant_vld_o = 1'b1;
      end else begin
        grant_vld_o = grant_vld_o;
      end
    end
  end

endmodule

// File: rtl/metric_accum_sched.sv
// Round-robin sign-extend-and-accumulate scheduler: NUM_CH sample streams share
// one adder; every 2^AVG_LOG2 samples a channel's sum goes out via a valid/ready register.
module metric_accum_sched
  import spgd_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int AVG_LOG2  = AVG_LOG2_DEF,
  localparam int CW       = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*IN_WIDTH-1:0]   in_data,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic [CW-1:0]                out_ch
);

  localparam logic [AVG_LOG2-1:0] CNT_MAX = {AVG_LOG2{1'b1}};

  logic [OUT_WIDTH-1:0] acc_q [NUM_CH];
  logic [OUT_WIDTH-1:0] acc_d [NUM_CH];
  logic [AVG_LOG2-1:0]  cnt_q [NUM_CH];
  logic [AVG_LOG2-1:0]  cnt_d [NUM_CH];
  logic [CW-1:0]        ptr_q, ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]        out_ch_q, out_ch_d;

  logic                 out_free;
  logic [NUM_CH-1:0]    elig;
  logic [NUM_CH-1:0]    gnt;
  logic [CW-1:0]        gidx;
  logic                 gvld;
  logic [IN_WIDTH-1:0]  smp;
  logic [63:0]          smp_w;
  logic [63:0]          ext_w;
  logic [OUT_WIDTH-1:0] sum;
  logic                 unused_ext;

  assign out_free = !out_valid_q || out_ready;

  // A channel at its last sample may only compete when the output register can take the sum.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_valid[i] && !clear && ((cnt_q[i] != CNT_MAX) || out_free)) begin
        elig[i] = 1'b1;
      end else begin
        elig[i] = 1'b0;
      end
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_arb (
    .req_i       (elig),
    .ptr_i       (ptr_q),
    .grant_o     (gnt),
    .grant_idx_o (gidx),
    .grant_vld_o (gvld)
  );

  assign in_ready = gnt;

  // Shared datapath: select granted sample, sign-extend, add to that channel's sum.
  always_comb begin
    smp   = in_data[int'(gidx)*IN_WIDTH +: IN_WIDTH];
    smp_w = '0;
    smp_w[IN_WIDTH-1:0] = smp;
    ext_w = sext(smp_w, IN_WIDTH);
    sum   = acc_q[gidx] + ext_w[OUT_WIDTH-1:0];
  end

  assign unused_ext = ^ext_w[63:OUT_WIDTH];

  // Next-state: clear beats everything; a completing grant reloads the output register.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
    end else if (gvld) begin
      if (gidx == CW'(NUM_CH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gidx + 1'b1;
      end
      if (cnt_q[gidx] == CNT_MAX) begin
        out_data_d  = sum;
        out_ch_d    = gidx;
        out_valid_d = 1'b1;
        acc_d[gidx] = '0;
        cnt_d[gidx] = '0;
      end else begin
        acc_d[gidx] = sum;
        cnt_d[gidx] = cnt_q[gidx] + 1'b1;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_metric_accum_sched.sv
// Directed self-checking bench for metric_accum_sched with hand-computed sums.
module tb_metric_accum_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [47:0] in_data;
  logic [3:0]  in_ready;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_ch;

  int total;
  int bad;

  metric_accum_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; in_valid = 4'b0000; in_data = 48'h0; clear = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input int ch, input logic [11:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 4'b0000;
      in_valid[ch] = 1'b1;
      in_data[ch*12 +: 12] = d;
      @(posedge clk); #1;
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b0000; in_data = 48'h0; clear = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 4'b0001; in_data[11:0] = 12'h001; #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", in_ready); end
    send(0, 12'h001, 15);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", out_valid); end
    send(0, 12'h001, 1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h0000_0010) begin bad++; $display("FAIL single_data got=%h exp=00000010", out_data); end
    total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL single_ch got=%0d exp=0", out_ch); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sign();
    out_ready = 1'b1;
    send(2, 12'h800, 16);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sign_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'hFFFF_8000) begin bad++; $display("FAIL sign_data got=%h exp=ffff8000", out_data); end
    total++; if (out_ch !== 2'd2) begin bad++; $display("FAIL sign_ch got=%0d exp=2", out_ch); end
    @(posedge clk); #1;
  endtask

  task automatic test_rotate();
    logic [3:0] e;
    do_reset();
    out_ready = 1'b1;
    in_data = {12'd4, 12'd3, 12'd2, 12'd1};
    in_valid = 4'b1111;
    for (int k = 0; k < 64; k++) begin
      e = 4'b0001 << (k % 4);
      #1;
      total++; if (in_ready !== e) begin bad++; $display("FAIL rot_grant k=%0d got=%b exp=%b", k, in_ready, e); end
      @(posedge clk); #1;
      if (k == 59) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rot_early got=%b exp=0", out_valid); end
      end else if (k >= 60) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rot_valid k=%0d got=%b exp=1", k, out_valid); end
        total++; if (out_ch !== 2'(k - 60)) begin bad++; $display("FAIL rot_ch k=%0d got=%0d exp=%0d", k, out_ch, k - 60); end
        total++; if (out_data !== 32'((k - 59) * 16)) begin bad++; $display("FAIL rot_data k=%0d got=%h exp=%h", k, out_data, 32'((k - 59) * 16)); end
      end
    end
    in_valid = 4'b0000;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rot_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_skip();
    logic [3:0] e [3];
    e[0] = 4'b0100; e[1] = 4'b1000; e[2] = 4'b0001;
    do_reset();
    out_ready = 1'b0;
    send(1, 12'd1, 15);
    send(0, 12'd2, 16);
    total++; if (out_data !== 32'd32 || out_valid !== 1'b1) begin bad++; $display("FAIL skip_pend got=%b/%h exp=1/00000020", out_valid, out_data); end
    in_data = {12'd1, 12'd1, 12'd5, 12'd1};
    in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in_ready !== e[k]) begin bad++; $display("FAIL skip_grant k=%0d got=%b exp=%b", k, in_ready, e[k]); end
      @(posedge clk); #1;
      total++; if (out_data !== 32'd32 || out_ch !== 2'd0) begin bad++; $display("FAIL skip_stable got=%h/%0d exp=00000020/0", out_data, out_ch); end
    end
    in_valid = 4'b0010; #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL skip_blocked got=%b exp=0000", in_ready); end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL skip_unblock got=%b exp=0010", in_ready); end
    @(posedge clk); #1;
    in_valid = 4'b0000;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL reload_valid got=%b exp=1", out_valid); end
    total++; if (out_ch !== 2'd1) begin bad++; $display("FAIL reload_ch got=%0d exp=1", out_ch); end
    total++; if (out_data !== 32'd20) begin bad++; $display("FAIL reload_data got=%h exp=00000014", out_data); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reload_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_clear();
    do_reset();
    out_ready = 1'b0;
    send(3, 12'd3, 7);
    send(0, 12'd1, 16);
    in_valid = 4'b1000; clear = 1'b1; #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL clear_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 4'b0000;
    total++; if (out_valid !== 1'b1 || out_data !== 32'd16 || out_ch !== 2'd0) begin bad++; $display("FAIL clear_pend got=%b/%h/%0d exp=1/00000010/0", out_valid, out_data, out_ch); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(3, 12'd1, 16);
    total++; if (out_valid !== 1'b1 || out_ch !== 2'd3) begin bad++; $display("FAIL clear_ch3 got=%b/%0d exp=1/3", out_valid, out_ch); end
    total++; if (out_data !== 32'd16) begin bad++; $display("FAIL clear_sum got=%h exp=00000010", out_data); end
    send(2, 12'd1, 15);
    in_valid = 4'b0100; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 4'b0000;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_wins got=%b exp=0", out_valid); end
    send(2, 12'd2, 16);
    total++; if (out_valid !== 1'b1 || out_data !== 32'd32 || out_ch !== 2'd2) begin bad++; $display("FAIL clear_ch2 got=%b/%h/%0d exp=1/00000020/2", out_valid, out_data, out_ch); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    do_reset();
    out_ready = 1'b0;
    send(0, 12'd1, 16);
    send(1, 12'd1, 5);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pend got=%b exp=1", out_valid); end
    #2; rst = 1'b1; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", out_data); end
    #1; rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1, 12'd1, 15);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early got=%b exp=0", out_valid); end
    send(1, 12'd1, 1);
    total++; if (out_valid !== 1'b1 || out_data !== 32'd16 || out_ch !== 2'd1) begin bad++; $display("FAIL rstmid_sum got=%b/%h/%0d exp=1/00000010/1", out_valid, out_data, out_ch); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_sign();
    test_rotate();
    test_skip();
    test_clear();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/metric_accum_sched.md
# metric_accum_sched

Round-robin scheduler that shares one sign-extend-and-accumulate datapath between NUM_CH signed ADC sample streams in the SPGD metric path. Each accepted IN_WIDTH-bit sample is sign-extended to OUT_WIDTH bits and added to that channel's running sum. After 2^AVG_LOG2 samples, the block emits the channel's sum with its channel index through a single-entry valid/ready output register. It sits between the ADC capture blocks and the gradient-estimation logic.

## Interface
- IN_WIDTH, 12, sample width, two's complement.
- OUT_WIDTH, 32, accumulated sum width; must be >= IN_WIDTH + AVG_LOG2.
- NUM_CH, 4, number of requesting channels, >= 2.
- AVG_LOG2, 4, log2 of samples per sum.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel sample valid.
- in_data  in  NUM_CH*IN_WIDTH  channel i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- in_ready  out  NUM_CH  per-channel accept; at most one bit high per cycle.
- clear  in  1  synchronous clear of all accumulators and counters.
- out_valid  out  1  sum available.
- out_ready  in  1  consumer accepts sum.
- out_data  out  OUT_WIDTH  signed sum of 2^AVG_LOG2 sign-extended samples.
- out_ch  out  CH_W  channel index of out_data; CH_W = max(1, clog2(NUM_CH)).

## Operation
- Per-channel state: acc[i] (OUT_WIDTH), cnt[i] (AVG_LOG2 bits), plus a global round-robin pointer ptr (CH_W).
- Eligibility: channel i is eligible when in_valid[i] = 1, clear = 0, and one of the following holds:
  - cnt[i] != 2^AVG_LOG2-1, or
  - the output register is free, meaning out_valid = 0 or out_ready = 1 this cycle.
- Grant: the first eligible channel searching from ptr upward, wrapping modulo NUM_CH.
  - in_ready[grant] = 1 combinationally; all other bits are 0.
  - No eligible channel means no grant and all in_ready bits are 0.
- Acceptance: a sample is accepted on any cycle where in_valid[g] and in_ready[g] are both high.
  - ptr <= (g+1) mod NUM_CH.
  - If no sample is accepted, ptr holds.
- Accumulate: sext = IN_WIDTH-bit sample with its MSB replicated to OUT_WIDTH. Arithmetic is modulo 2^OUT_WIDTH.
  - If cnt[g] != max: acc[g] <= acc[g] + sext and cnt[g] <= cnt[g] + 1.
  - If cnt[g] == max:
    - out_data <= acc[g] + sext, out_ch <= g, out_valid <= 1;
    - acc[g] <= 0, cnt[g] <= 0.
- Output register: out_valid falls on out_valid && out_ready unless it is reloaded in the same cycle; reload has priority.
- Output data and skipping: out_data and out_ch are stable while out_valid && !out_ready. A completing channel that is blocked is skipped, and lower-priority channels may still be granted.
- clear: zeroes every acc and cnt. All in_ready bits are 0 during clear. ptr and the output register are unaffected, so a pending sum is still delivered.
- Ignored input: in_data of a channel that is not granted is ignored.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, all acc and cnt = 0. in_ready follows combinationally, so it is all 0 while all in_valid = 0.
- Latency: a completing sample accepted in cycle N gives out_valid = 1 in cycle N+1.
- Throughput: one sample per cycle aggregate. Back-to-back sums are possible when out_ready is held high.
- in_ready depends combinationally on in_valid, clear, out_valid and out_ready. It has no dependency on in_data.
- Reset mid-sum discards all partial sums and any pending output.
- Simultaneous events:
  - clear and a completing request in the same cycle: clear wins, and nothing is loaded.
  - Drain and reload in the same cycle: the new sum is presented in the next cycle with no bubble.

## Structure
- Shared package spgd_pkg: function clog2, function sext(IN_WIDTH to OUT_WIDTH), localparam CH_W.
- Sub-module rr_arbiter (NUM_CH): inputs req[NUM_CH] and ptr; output one-hot grant plus its index. Purely combinational; ptr is held in the parent.
- Accumulators: a register array in the parent, with a single shared adder muxed by the grant index.

## Test plan
- Reset, then channel 0 sends 16 samples of 12'h001 with out_ready = 1 -> out_valid one cycle after the 16th sample, out_data = 32'h0000_0010, out_ch = 0.
- Channel 2 sends 16 samples of 12'h800 (-2048) -> out_data = 32'hFFFF_8000, verifying sign extension.
- All four channels hold in_valid continuously -> grants rotate 0,1,2,3,0,...; each channel's sum is emitted every 64 cycles in channel order.
- out_ready = 0 while channel 1 is at cnt = 15 with a sum pending -> channel 1 is skipped and channels 0, 2, 3 are still granted. Raising out_ready gives drain and reload in the same cycle, and the channel 1 sum appears the next cycle.
- clear asserted after 7 samples on channel 3, while a sum is pending -> the pending sum is still delivered, and the next channel 3 sum reflects only post-clear samples.
- rst asserted mid-accumulation with out_valid = 1 -> out_valid drops immediately (asynchronous), and the next sum starts from a zero count.
